// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver on a single system clock.
//
// The pin is double-flopped into rx_s. A registered falling-edge detector
// starts a frame. Each bit is sampled near its middle, timed from the start
// edge. A good stop bit loads the byte and gives a one-cycle valid pulse. A
// low stop bit gives a one-cycle framing-error pulse, and the receiver then
// waits for the line to return high. This stops a break (line held low) from
// being decoded as a run of frames.
//
// Ports:
//   i_clk          system clock; all flops use its rising edge
//   i_rst          asynchronous active-high reset
//   i_uart_rx      serial input, asynchronous to i_clk, idle high
//   o_rx_data      last correctly received byte, held until the next good frame
//   o_rx_valid     one-cycle pulse when o_rx_data has just updated
//   o_rx_frame_err one-cycle pulse when the stop bit is sampled low
//   o_uart_busy    high whenever the receiver is not idle
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 200_000_000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_frame_err,
  output logic       o_uart_busy
);

  localparam int CLOCKS_PER_BAUD = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BAUD       = CLOCKS_PER_BAUD / 2;
  localparam int CNT_W           = $clog2(CLOCKS_PER_BAUD) + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BAUD - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Synchroniser and edge detector.
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;
  logic fall_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic half_hit;
  logic full_hit;

  assign half_hit = (cnt_q == HALF_LAST);
  assign full_hit = (cnt_q == FULL_LAST);

  // The edge flag is registered, so each sample falls one clock later in its
  // bit. This keeps the stop-bit sample inside the stop bit when the
  // transmitter runs one clock per bit slow (CLOCKS_PER_BAUD+1).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      fall_q    <= rx_prev_q & ~rx_s_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (fall_q) state_d = S_START;
      S_START:     if (half_hit) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:      if (full_hit && (bit_idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:      if (full_hit) state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Counter, shift register and output pulses.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
      end
      S_START: begin
        if (half_hit) begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (full_hit) begin
          // LSB arrives first, so shift in from the top.
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (full_hit) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        // The timing reference is lost, so the counter stays at zero.
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign o_rx_data      = data_q;
  assign o_rx_valid     = valid_q;
  assign o_rx_frame_err = err_q;
  assign o_uart_busy    = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the team's `uart_tx`, on the same single system clock. Deserialises 8N1 frames from an asynchronous serial pin into bytes, with mid-bit sampling and start-bit validation. Each good byte is presented as a one-cycle valid pulse, and framing errors are flagged. It sits between the board RX pin and the command/debug logic that consumes bytes.

## Interface

Parameters:
- `CLOCK_FREQUENCY`, default 200_000_000: `i_clk` frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- Derived: `CLOCKS_PER_BAUD = CLOCK_FREQUENCY/BAUD_RATE` (integer divide) and `HALF_BAUD = CLOCKS_PER_BAUD/2`.
- Counter width: `$clog2(CLOCKS_PER_BAUD)+1` bits.

Ports:
- `i_clk`  in  1  system clock. One clock only; every flop is on its rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_uart_rx`  in  1  serial input, asynchronous to `i_clk`, idle high.
- `o_rx_data`  out  8  last correctly received byte. Held until the next good frame.
- `o_rx_valid`  out  1  one-cycle pulse when `o_rx_data` has just updated.
- `o_rx_frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `o_uart_busy`  out  1  high in every state except IDLE.

## Operation

- Synchroniser:
  - `i_uart_rx` passes through 2 flops; both reset to 1.
  - All logic below uses only the synchronised signal `rx_s`.
  - A falling edge is detected from `rx_s` and a third registered copy of it.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on a falling edge of `rx_s`, clear the baud counter and go to START.
  - START: when the counter reaches `HALF_BAUD-1`, sample `rx_s`.
    - Sample 0: clear the counter and bit index, go to DATA.
    - Sample 1: glitch. Return to IDLE with no output pulse.
  - DATA: when the counter reaches `CLOCKS_PER_BAUD-1`, sample `rx_s` into the shift register, LSB first, then clear the counter.
    - After the 8th sample (bit index 7), go to STOP.
  - STOP: when the counter reaches `CLOCKS_PER_BAUD-1`, sample `rx_s`.
    - Sample 1: load `o_rx_data` from the shift register, pulse `o_rx_valid`, go to IDLE.
    - Sample 0: pulse `o_rx_frame_err`, leave `o_rx_data` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` = 1, then go to IDLE. This handles break conditions: a held-low line produces exactly one error, not repeated frames.
- Only 1 stop bit is required. Extra stop bits (the transmitter sends 3) are idle-high time.
- A start edge is accepted on the first cycle back in IDLE, so back-to-back frames are received.
- The baud counter runs only outside IDLE and is held at 0 in IDLE.
- Sampling is at mid-bit, from the start-edge reference. This tolerates a per-frame bit-period mismatch of at least ±3%; the transmitter's `CLOCKS_PER_BAUD+1` period is within this.
- Reset mid-frame:
  - State goes to IDLE and all outputs go to 0.
  - The shift register and bit index are cleared.
  - The synchroniser goes to 1, so a line held low after reset is not taken as a start until it first goes high.

## Timing

Reset values:
- `o_rx_data` = 8'h00.
- `o_rx_valid` = 0.
- `o_rx_frame_err` = 0.
- `o_uart_busy` = 0.
- FSM in IDLE; counter 0.

Latency and output behaviour:
- Pin to `rx_s`: 2 cycles.
- Start edge on pin to `o_rx_valid`: 3 + `HALF_BAUD` + 9·`CLOCKS_PER_BAUD` + 1 cycles, ±1 cycle allowed.
- `o_rx_valid` and `o_rx_data` update on the same edge. `o_rx_valid` is high for exactly 1 cycle.
- `o_rx_valid` and `o_rx_frame_err` are never high together.
- No back-pressure: the consumer must take the byte within one frame time. A new good frame overwrites `o_rx_data` with no overrun indication.
- `o_uart_busy` rises 1 cycle after the edge is detected in `rx_s` and falls on entry to IDLE.

## Test plan

All tests use `CLOCK_FREQUENCY`=16, `BAUD_RATE`=1, giving `CLOCKS_PER_BAUD`=16 and `HALF_BAUD`=8.

1. Reset and idle: assert `i_rst` mid-run, then hold `i_uart_rx`=1 for 500 cycles → all outputs 0 throughout; no pulses.
2. Single byte: drive 0xA5 at 16 cycles/bit with 1 stop bit → one `o_rx_valid` pulse, `o_rx_data`=8'hA5, within the latency ±1.
3. Back-to-back stream: send 0x00, 0xFF, 0x3C using the `uart_tx` bit pattern (17 cycles/bit, 3 stop bits) → three valid pulses carrying 00, FF, 3C in order; no frame errors.
4. Glitch rejection: 4-cycle low pulse on an idle line → no pulses, `o_rx_data` unchanged, `o_uart_busy` back to 0 within 11 cycles.
5. Framing error and break: send 0x55 with the stop bit low, then hold the line low for 200 cycles, then raise it and send 0x12:
   - exactly one `o_rx_frame_err` pulse;
   - `o_rx_data` stays at its previous value;
   - then one valid pulse with 8'h12.
6. Reset mid-frame: assert `i_rst` during bit 4 of 0x81, release it, then send 0x7E → no pulse for the aborted frame; one valid pulse with 8'h7E.
